// File: rtl/image_stream_gen.sv
// image_stream_gen: synthetic framed image-stream transmitter.
// Emits FRAME_START, per-row ROW_START / pixels / ROW_END, optional horizontal
// blanking, FRAME_END and a META_WORDS-long header region on the
// dvo/dtypeo/datao/meta_datao bus.
// Optional feature macro: IMAGE_STREAM_GEN_LFSR_EN (pattern 3 = 16-bit LFSR;
// when undefined no LFSR is built and pattern 3 produces the ramp).

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'd2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'd4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'd5
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 4'd6
`endif

module image_stream_gen #(
  parameter int PIXEL_WIDTH    = 8,
  parameter int MAX_COLS_WIDTH = 11,
  parameter int MAX_ROWS_WIDTH = 11,
  parameter int META_WORDS     = 4
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      enable,
  input  logic                      start,
  input  logic [MAX_COLS_WIDTH-1:0] num_cols,
  input  logic [MAX_ROWS_WIDTH-1:0] num_rows,
  input  logic [7:0]                hblank,
  input  logic [1:0]                pattern,
  output logic                      busy,
  output logic [15:0]               frame_count,
  output logic                      dvo,
  output logic [`DTYPE_WIDTH-1:0]   dtypeo,
  output logic [PIXEL_WIDTH-1:0]    datao,
  output logic [15:0]               meta_datao
);

  // Header index counter must be able to hold META_WORDS-1.
  localparam int META_W = (META_WORDS > 1) ? $clog2(META_WORDS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FSTART = 3'd1,
    ST_RSTART = 3'd2,
    ST_PIX    = 3'd3,
    ST_REND   = 3'd4,
    ST_HBLANK = 3'd5,
    ST_FEND   = 3'd6,
    ST_META   = 3'd7
  } state_t;

  state_t                    state_r;
  logic [MAX_COLS_WIDTH-1:0] cols_r;
  logic [MAX_COLS_WIDTH-1:0] col_r;
  logic [MAX_ROWS_WIDTH-1:0] rows_r;
  logic [MAX_ROWS_WIDTH-1:0] row_r;
  logic [7:0]                hblank_r;
  logic [7:0]                hb_cnt_r;
  logic [1:0]                pattern_r;
  logic [META_W-1:0]         meta_k_r;
  logic [15:0]               frame_id_r;

  logic [PIXEL_WIDTH-1:0]    pixel_s;
  logic [31:0]               ramp_s;
  logic [31:0]               meta_idx_s;
  logic                      last_col_s;
  logic                      last_row_s;
  logic                      last_meta_s;
  logic                      accept_s;

`ifdef IMAGE_STREAM_GEN_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_r;
  logic [31:0] lfsr_ext_s;

  // One step of the Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction
`endif

  // Pixel value, end-of-row/frame/meta flags and start acceptance.
  always_comb begin
    ramp_s      = 32'(col_r) + 32'(row_r);
    meta_idx_s  = 32'(meta_k_r);
    last_col_s  = (col_r == (cols_r - MAX_COLS_WIDTH'(1'b1)));
    last_row_s  = (row_r == (rows_r - MAX_ROWS_WIDTH'(1'b1)));
    last_meta_s = (meta_k_r == META_W'(META_WORDS - 1));
    accept_s    = start && enable &&
                  (num_cols != {MAX_COLS_WIDTH{1'b0}}) &&
                  (num_rows != {MAX_ROWS_WIDTH{1'b0}});
`ifdef IMAGE_STREAM_GEN_LFSR_EN
    lfsr_ext_s  = {16'd0, lfsr_r};
`endif
    case (pattern_r)
      2'd0: pixel_s = ramp_s[PIXEL_WIDTH-1:0];
      2'd1: pixel_s = {PIXEL_WIDTH{1'b1}};
      2'd2: begin
        if (col_r[3] ^ row_r[3]) begin
          pixel_s = {PIXEL_WIDTH{1'b1}};
        end else begin
          pixel_s = {PIXEL_WIDTH{1'b0}};
        end
      end
`ifdef IMAGE_STREAM_GEN_LFSR_EN
      2'd3: pixel_s = lfsr_ext_s[PIXEL_WIDTH-1:0];
`else
      2'd3: pixel_s = ramp_s[PIXEL_WIDTH-1:0];
`endif
      default: pixel_s = ramp_s[PIXEL_WIDTH-1:0];
    endcase
  end

  // Frame sequencer: each state registers the bus word it emits and picks the next state.
  always_ff @(posedge clk) begin
    if (resetb) begin
      state_r     <= ST_IDLE;
      cols_r      <= {MAX_COLS_WIDTH{1'b0}};
      col_r       <= {MAX_COLS_WIDTH{1'b0}};
      rows_r      <= {MAX_ROWS_WIDTH{1'b0}};
      row_r       <= {MAX_ROWS_WIDTH{1'b0}};
      hblank_r    <= 8'd0;
      hb_cnt_r    <= 8'd0;
      pattern_r   <= 2'd0;
      meta_k_r    <= {META_W{1'b0}};
      frame_id_r  <= 16'd0;
      busy        <= 1'b0;
      frame_count <= 16'd0;
      dvo         <= 1'b0;
      dtypeo      <= {`DTYPE_WIDTH{1'b0}};
      datao       <= {PIXEL_WIDTH{1'b0}};
      meta_datao  <= 16'd0;
`ifdef IMAGE_STREAM_GEN_LFSR_EN
      lfsr_r      <= LFSR_SEED;
`endif
    end else if (!enable) begin
      // Abort: drop the frame silently, no FRAME_END, frame_count held.
      state_r    <= ST_IDLE;
      busy       <= 1'b0;
      dvo        <= 1'b0;
      dtypeo     <= {`DTYPE_WIDTH{1'b0}};
      datao      <= {PIXEL_WIDTH{1'b0}};
      meta_datao <= 16'd0;
    end else begin
      // Bus is idle unless the current state emits a word below.
      dvo        <= 1'b0;
      dtypeo     <= {`DTYPE_WIDTH{1'b0}};
      datao      <= {PIXEL_WIDTH{1'b0}};
      meta_datao <= 16'd0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cols_r     <= num_cols;
            rows_r     <= num_rows;
            hblank_r   <= hblank;
            pattern_r  <= pattern;
            col_r      <= {MAX_COLS_WIDTH{1'b0}};
            row_r      <= {MAX_ROWS_WIDTH{1'b0}};
            meta_k_r   <= {META_W{1'b0}};
            frame_id_r <= frame_count;
            busy       <= 1'b1;
            state_r    <= ST_FSTART;
`ifdef IMAGE_STREAM_GEN_LFSR_EN
            lfsr_r     <= LFSR_SEED;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        ST_FSTART: begin
          dvo        <= 1'b1;
          dtypeo     <= `DTYPE_FRAME_START;
          meta_datao <= frame_id_r;
          state_r    <= ST_RSTART;
        end
        ST_RSTART: begin
          dvo        <= 1'b1;
          dtypeo     <= `DTYPE_ROW_START;
          meta_datao <= frame_id_r;
          state_r    <= ST_PIX;
        end
        ST_PIX: begin
          dvo        <= 1'b1;
          dtypeo     <= `DTYPE_PIXEL;
          datao      <= pixel_s;
          meta_datao <= frame_id_r;
`ifdef IMAGE_STREAM_GEN_LFSR_EN
          lfsr_r     <= lfsr_next(lfsr_r);
`endif
          if (last_col_s) begin
            col_r   <= {MAX_COLS_WIDTH{1'b0}};
            state_r <= ST_REND;
          end else begin
            col_r <= col_r + MAX_COLS_WIDTH'(1'b1);
          end
        end
        ST_REND: begin
          dvo        <= 1'b1;
          dtypeo     <= `DTYPE_ROW_END;
          meta_datao <= frame_id_r;
          if (hblank_r != 8'd0) begin
            // HBLANK lasts hb_cnt_r+1 cycles, i.e. exactly hblank_r.
            hb_cnt_r <= hblank_r - 8'd1;
            state_r  <= ST_HBLANK;
          end else if (last_row_s) begin
            state_r <= ST_FEND;
          end else begin
            row_r   <= row_r + MAX_ROWS_WIDTH'(1'b1);
            state_r <= ST_RSTART;
          end
        end
        ST_HBLANK: begin
          if (hb_cnt_r != 8'd0) begin
            hb_cnt_r <= hb_cnt_r - 8'd1;
          end else if (last_row_s) begin
            state_r <= ST_FEND;
          end else begin
            row_r   <= row_r + MAX_ROWS_WIDTH'(1'b1);
            state_r <= ST_RSTART;
          end
        end
        ST_FEND: begin
          dvo         <= 1'b1;
          dtypeo      <= `DTYPE_FRAME_END;
          meta_datao  <= frame_id_r;
          frame_count <= frame_count + 16'd1;
          meta_k_r    <= {META_W{1'b0}};
          state_r     <= ST_META;
        end
        ST_META: begin
          dvo        <= 1'b1;
          dtypeo     <= `DTYPE_HEADER;
          datao      <= meta_idx_s[PIXEL_WIDTH-1:0];
          meta_datao <= frame_id_r;
          if (last_meta_s) begin
            // busy drops here so a start in the next cycle is accepted.
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            meta_k_r <= meta_k_r + META_W'(1'b1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_stream_gen.sv
// Self-checking bench for image_stream_gen: every frame is predicted cycle by
// cycle by a behavioural model (nested row/column loops) and compared on the
// falling clock edge.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'd2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'd4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'd5
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 4'd6
`endif

module tb_image_stream_gen;

  localparam int PW = 8;
  localparam int CW = 11;
  localparam int RW = 11;
  localparam int MW = 4;

  logic              clk;
  logic              resetb;
  logic              enable;
  logic              start;
  logic [CW-1:0]     num_cols;
  logic [RW-1:0]     num_rows;
  logic [7:0]        hblank;
  logic [1:0]        pattern;
  logic              busy;
  logic [15:0]       frame_count;
  logic              dvo;
  logic [`DTYPE_WIDTH-1:0] dtypeo;
  logic [PW-1:0]     datao;
  logic [15:0]       meta_datao;

  image_stream_gen #(
    .PIXEL_WIDTH(PW), .MAX_COLS_WIDTH(CW), .MAX_ROWS_WIDTH(RW), .META_WORDS(MW)
  ) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .start(start),
    .num_cols(num_cols), .num_rows(num_rows), .hblank(hblank), .pattern(pattern),
    .busy(busy), .frame_count(frame_count), .dvo(dvo), .dtypeo(dtypeo),
    .datao(datao), .meta_datao(meta_datao)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v;
    int dt;
    int d;
    int meta;
    int fc;
    int b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   exp_fc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int pix_model(input int c, input int r, input int pat, input int lf);
    int mask;
    mask = (1 << PW) - 1;
    case (pat)
      1: return mask;
      2: return ((((c >> 3) ^ (r >> 3)) & 1) != 0) ? mask : 0;
`ifdef IMAGE_STREAM_GEN_LFSR_EN
      3: return lf & mask;
`endif
      default: return (c + r) & mask;
    endcase
  endfunction

  task automatic push(input int v, input int dt, input int d, input int fc);
    exp_t e;
    e.v = v; e.dt = dt; e.d = d; e.meta = exp_fc; e.fc = fc; e.b = 1;
    exp_q.push_back(e);
  endtask

  // Whole-frame prediction from FRAME_START to the last header word.
  task automatic build_expected(input int cols, input int rows, input int hb, input int pat);
    int lf;
    int fb;
    exp_q.delete();
    lf = 16'hACE1;
    push(1, `DTYPE_FRAME_START, 0, exp_fc);
    for (int r = 0; r < rows; r++) begin
      push(1, `DTYPE_ROW_START, 0, exp_fc);
      for (int c = 0; c < cols; c++) begin
        push(1, `DTYPE_PIXEL, pix_model(c, r, pat, lf), exp_fc);
        fb = (lf ^ (lf >> 2) ^ (lf >> 3) ^ (lf >> 5)) & 1;
        lf = (lf >> 1) | (fb << 15);
      end
      push(1, `DTYPE_ROW_END, 0, exp_fc);
      for (int h = 0; h < hb; h++) push(0, 0, 0, exp_fc);
    end
    push(1, `DTYPE_FRAME_END, 0, (exp_fc + 1) & 16'hFFFF);
    for (int k = 0; k < MW; k++) push(1, `DTYPE_HEADER, k & ((1 << PW) - 1), (exp_fc + 1) & 16'hFFFF);
    exp_q[exp_q.size() - 1].b = 0;
  endtask

  // Start a frame; with wait_first=0 the start is raised in the current cycle.
  task automatic launch(input int c, input int r, input int h, input int p, input bit wait_first);
    if (wait_first) begin
      @(negedge clk);
      check_val("idle_busy", busy, 0);
    end
    build_expected(c, r, h, p);
    num_cols = CW'(c);
    num_rows = RW'(r);
    hblank   = 8'(h);
    pattern  = 2'(p);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("acc_busy", busy, 1);
    check_val("acc_dvo", dvo, 0);
  endtask

  // Compare the first n predicted cycles; optionally pulse start with a new config at item poke_at.
  task automatic stream_check(input int n, input int poke_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == poke_at + 1) start = 1'b0;
      check_val($sformatf("w%0d_dvo", i), dvo, exp_q[i].v);
      check_val($sformatf("w%0d_busy", i), busy, exp_q[i].b);
      check_val($sformatf("w%0d_fc", i), frame_count, exp_q[i].fc);
      if (exp_q[i].v != 0) begin
        check_val($sformatf("w%0d_dtype", i), dtypeo, exp_q[i].dt);
        check_val($sformatf("w%0d_data", i), datao, exp_q[i].d);
        check_val($sformatf("w%0d_meta", i), meta_datao, exp_q[i].meta);
      end
      if (i == poke_at) begin
        num_cols = CW'(7);
        num_rows = RW'(3);
        start    = 1'b1;
      end
    end
  endtask

  task automatic full_frame(input int c, input int r, input int h, input int p, input bit wait_first);
    launch(c, r, h, p, wait_first);
    stream_check(exp_q.size(), -1);
    exp_fc = (exp_fc + 1) & 16'hFFFF;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_val({tag, "_dvo"}, dvo, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_fc"}, frame_count, exp_fc);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_fc   = 0;
    resetb   = 1'b1;
    enable   = 1'b1;
    start    = 1'b0;
    num_cols = '0;
    num_rows = '0;
    hblank   = 8'd0;
    pattern  = 2'd0;

    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_fc", frame_count, 0);
    check_val("rst_dvo", dvo, 0);
    check_val("rst_dtype", dtypeo, 0);
    check_val("rst_data", datao, 0);
    check_val("rst_meta", meta_datao, 0);
    resetb = 1'b0;

    // Reference 4x2 ramp, then same with hblank=3 back to back.
    full_frame(4, 2, 0, 0, 1'b1);
    full_frame(4, 2, 3, 0, 1'b0);

    // Start with a different config pulsed mid-frame must be ignored.
    launch(4, 2, 0, 2, 1'b1);
    stream_check(exp_q.size(), 5);
    exp_fc++;
    expect_quiet("midstart", 3);

    // Zero rows / zero cols are rejected.
    num_cols = CW'(5); num_rows = RW'(0); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val("zrows_busy", busy, 0);
    expect_quiet("zrows", 3);
    num_cols = CW'(0); num_rows = RW'(3); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val("zcols_busy", busy, 0);
    expect_quiet("zcols", 3);

    // start coinciding with enable falling is not accepted.
    num_cols = CW'(3); num_rows = RW'(2); start = 1'b1; enable = 1'b0;
    @(negedge clk); start = 1'b0; enable = 1'b1;
    check_val("en_start_busy", busy, 0);
    expect_quiet("en_start", 3);

    // Randomised frames, sometimes back to back.
    full_frame(3, 1, 0, 1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      int c, r, h, p, b2b;
      c   = $urandom_range(1, 20);
      r   = $urandom_range(1, 6);
      h   = $urandom_range(0, 4);
      p   = $urandom_range(0, 3);
      b2b = $urandom_range(0, 1);
      full_frame(c, r, h, p, b2b == 0);
    end
    // Checkerboard transitions need columns/rows beyond 8.
    full_frame(20, 12, 0, 2, 1'b1);

    // Pattern 3 twice: identical frames (LFSR reseeded, or ramp without LFSR).
    full_frame(6, 2, 0, 3, 1'b1);
`ifdef IMAGE_STREAM_GEN_LFSR_EN
    check_val("lfsr_first_pix_model", exp_q[2].d, 32'hE1);
`endif
    full_frame(6, 2, 0, 3, 1'b0);

    // enable dropped during row 1 pixels: stop next cycle, no FRAME_END.
    launch(6, 3, 1, 0, 1'b1);
    stream_check(13, -1);
    enable = 1'b0;
    expect_quiet("abort", 3);
    enable = 1'b1;
    full_frame(4, 2, 0, 0, 1'b1);

    // Reset for one cycle mid-pixels, then the reference frame again.
    launch(4, 2, 0, 0, 1'b1);
    stream_check(4, -1);
    resetb = 1'b1;
    @(negedge clk);
    resetb = 1'b0;
    exp_fc = 0;
    check_val("mrst_dvo", dvo, 0);
    check_val("mrst_busy", busy, 0);
    check_val("mrst_fc", frame_count, 0);
    check_val("mrst_dtype", dtypeo, 0);
    check_val("mrst_data", datao, 0);
    check_val("mrst_meta", meta_datao, 0);
    full_frame(4, 2, 0, 0, 1'b1);
    expect_quiet("final", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_stream_gen.md
# image_stream_gen

Synthetic image-stream transmitter that produces complete framed pixel streams on the team's `dvo/dtypeo/datao/meta_datao` bus. It emits frame/row delimiters, pixels and a trailing meta region. It drives `filter2d`, `kernel` and other stream consumers in simulation and in on-chip self-test, replacing the sensor front end.

## Interface
Parameters:
- PIXEL_WIDTH, 8, pixel bits on `datao`
- MAX_COLS_WIDTH, 11, width of column count/counter
- MAX_ROWS_WIDTH, 11, width of row count/counter
- META_WORDS, 4, number of `DTYPE_HEADER words after FRAME_END (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- resetb  in  1  reset; synchronous, active-high (1 = reset), sampled on `clk`
- enable  in  1  0 aborts/holds generator in IDLE
- start  in  1  single-cycle request for one frame
- num_cols  in  MAX_COLS_WIDTH  pixels per row, sampled at accepted start
- num_rows  in  MAX_ROWS_WIDTH  rows per frame, sampled at accepted start
- hblank  in  8  idle cycles after each ROW_END, sampled at accepted start
- pattern  in  2  0 ramp, 1 constant max, 2 checkerboard, 3 LFSR (see Configuration)
- busy  out  1  1 from accepted start through last meta word
- frame_count  out  16  completed frames, +1 on each FRAME_END emitted, wraps
- dvo  out  1  output word valid
- dtypeo  out  `DTYPE_WIDTH  word type
- datao  out  PIXEL_WIDTH  word data
- meta_datao  out  16  current frame_count on every valid word

## Operation
- FSM states: IDLE, FSTART, RSTART, PIX, REND, HBLANK, FEND, META.
- IDLE: `dvo`=0. Accept start when `start && enable && num_cols!=0 && num_rows!=0`. Latch config, clear row/col, go FSTART, set busy.
- FSTART: emit `DTYPE_FRAME_START, datao=0 -> RSTART.
- RSTART: emit `DTYPE_ROW_START, datao=0 -> PIX.
- PIX: emit `DTYPE_PIXEL, one per cycle, col 0..num_cols-1. At col=num_cols-1 -> REND.
- REND: emit `DTYPE_ROW_END. If hblank=0, go to RSTART, or to FEND on the last row. Otherwise go HBLANK.
- HBLANK: `dvo`=0 for exactly hblank cycles, then RSTART (row+1) or FEND if row=num_rows-1.
- FEND: emit `DTYPE_FRAME_END, datao=0; frame_count+1 -> META.
- META: emit META_WORDS words of `DTYPE_HEADER, datao=word index k (0..META_WORDS-1, truncated) -> IDLE; busy=0 after last word.
- Pixel data (row r, col c, truncated to PIXEL_WIDTH):
  - ramp: c+r.
  - constant: all ones.
  - checkerboard: (c[3]^r[3]) ? all ones : 0.
- meta_datao = frame_count before the FEND increment, for all words of a frame, META included.
- Boundaries:
  - start while busy: ignored.
  - zero num_cols or num_rows: start ignored, busy stays 0.
  - Config changes mid-frame: ignored.
  - enable=0 in any state: next cycle IDLE, `dvo`=0, busy=0, no FRAME_END, frame_count unchanged.
  - start and enable falling in the same cycle: start not accepted.
  - resetb mid-frame: next cycle IDLE, `dvo`=0, dtypeo=0, datao=0, meta_datao=0, busy=0, frame_count=0, LFSR=seed.

## Timing
- All outputs are registered. Reset value of every output is 0.
- start accepted at edge t: busy=1 and FRAME_START valid after edge t+1.
- Cycles from first FRAME_START to last META word inclusive: 2 + num_rows·(num_cols+2+hblank) + META_WORDS.
- Next start is accepted in the cycle busy reads 0, giving back-to-back frames with one idle cycle.

## Configuration
- `IMAGE_STREAM_GEN_LFSR_EN` defined:
  - pattern=3 selects a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1). datao = low PIXEL_WIDTH bits.
  - The LFSR advances only on PIX cycles and reseeds at each accepted start, so frames are identical.
- Not defined: no LFSR logic is built, and pattern=3 behaves as ramp.

## Test plan
- num_cols=4, num_rows=2, hblank=0, pattern=0, META_WORDS=4 -> exact sequence FS, RS, 0,1,2,3, RE, RS, 1,2,3,4, RE, FE, H0..H3. That is 18 valid words, contiguous, with frame_count 0→1 after FE and meta_datao=0 throughout.
- Same config with hblank=3 -> exactly 3 `dvo`=0 cycles after each RE; total 24 cycles start-to-last-META.
- start pulsed mid-frame and with num_rows=0 -> ignored: no second FS, busy unaffected/0.
- enable dropped during row 1 PIX, then start again -> stream stops next cycle without FE. New frame begins with FS, meta_datao=0.
- resetb asserted 1 cycle mid-PIX -> all outputs 0 next cycle, frame_count=0. A subsequent frame matches the first scenario.
- With `IMAGE_STREAM_GEN_LFSR_EN`, pattern=3, two consecutive frames -> identical pixel sequences, first pixel = 8'hE1 for PIXEL_WIDTH=8.
